// File: rtl/icache_controller.sv
// Direct-mapped 8x16B instruction cache: zero-cycle hits, blocking line fill on miss.
// Latency: hit same cycle; miss = 1 lookup + memory cycles + 1 fill, then re-lookup hits.
// Backpressure: BUSYWAIT stalls the CPU; waits on MEM_BUSYWAIT. Optional counters: ICACHE_STATS_EN.
module icache_controller (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic [5:0]   MEM_ADDRESS,
    output logic         MEM_READ,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]  HIT_COUNT,
    output logic [15:0]  MISS_COUNT
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     addr_q, addr_d;
    logic [127:0]   fill_q, fill_d;
    logic           mem_read_q, mem_read_d;
    logic [7:0]     valid_q, valid_d;
    logic [2:0]     tag_q  [8];
    logic [127:0]   data_q [8];

    logic [1:0]     pc_offset;
    logic [2:0]     pc_index;
    logic [2:0]     pc_tag;
    logic           unused_pc_bits;
    logic           line_hit;
    logic           lookup_hit;
    logic           fill_we;
    logic [127:0]   line_data;
    logic [31:0]    line_word;

    assign pc_offset      = PC[3:2];
    assign pc_index       = PC[6:4];
    assign pc_tag         = PC[9:7];
    assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

    assign line_hit   = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign lookup_hit = !RESET && (state_q == IDLE) && line_hit;
    assign fill_we    = (state_q == FILL);
    assign line_data  = data_q[pc_index];
    assign line_word  = line_data[{pc_offset, 5'd0} +: 32];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_read_d = mem_read_q;
        valid_d    = valid_q;
        fill_d     = fill_q;
        case (state_q)
            IDLE: begin
                if (!line_hit) begin
                    state_d    = FETCH;
                    addr_d     = {pc_tag, pc_index};
                    mem_read_d = 1'b1;
                end
            end
            FETCH: begin
                // The block is captured only on the terminating edge; later bus values are ignored.
                if (!MEM_BUSYWAIT) begin
                    state_d    = FILL;
                    fill_d     = MEM_READDATA;
                    mem_read_d = 1'b0;
                end
            end
            FILL: begin
                state_d             = IDLE;
                valid_d[addr_q[2:0]] = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mem_read_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_read_q <= mem_read_d;
            valid_q    <= valid_d;
        end
    end

    // Tag/data storage carries no reset; the valid bits alone qualify a line.
    always_ff @(posedge CLK) begin
        fill_q <= fill_d;
        if (fill_we && !RESET) begin
            tag_q[addr_q[2:0]]  <= addr_q[5:3];
            data_q[addr_q[2:0]] <= fill_q;
        end
    end

    assign BUSYWAIT    = !RESET && !lookup_hit;
    assign INSTRUCTION = lookup_hit ? line_word : 32'd0;
    assign MEM_READ    = mem_read_q && !RESET;
    assign MEM_ADDRESS = RESET ? 6'd0 : addr_q;

`ifdef ICACHE_STATS_EN
    logic        lookup_miss;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    assign lookup_miss = !RESET && (state_q == IDLE) && !line_hit;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup_hit && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (lookup_miss && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Randomized bench for icache_controller against a line-level cache model and a latency-programmable memory.
module tb_icache_controller;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic [5:0]   MEM_ADDRESS;
    logic         MEM_READ;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [15:0]  HIT_COUNT;
    logic [15:0]  MISS_COUNT;
`endif

    icache_controller dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READ     (MEM_READ),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int           checks   = 0;
    int           failures = 0;
    logic [127:0] mem_img [64];
    bit           m_valid [8];
    logic [2:0]   m_tag   [8];
    logic [127:0] m_data  [8];
    int           m_hits   = 0;
    int           m_misses = 0;
    int           mem_lat  = 1;
    int           mem_cnt  = 0;
    int           bursts   = 0;
    logic         rd_prev  = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] off);
        logic [127:0] sh;
        sh = blk >> (32 * off);
        return sh[31:0];
    endfunction

    // Memory: holds MEM_BUSYWAIT for mem_lat-1 read cycles, returns the block on the last one, garbage otherwise.
    always @(negedge CLK) begin
        if (MEM_READ) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                MEM_BUSYWAIT = 1'b0;
                MEM_READDATA = mem_img[MEM_ADDRESS];
            end else begin
                MEM_BUSYWAIT = 1'b1;
                MEM_READDATA = rand128();
            end
        end else begin
            mem_cnt      = 0;
            MEM_BUSYWAIT = 1'($urandom);
            MEM_READDATA = rand128();
        end
        if (MEM_READ && !rd_prev) bursts++;
        rd_prev = MEM_READ;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_pc(input logic [9:0] a);
        logic [31:0] p;
        p      = $urandom;
        p[9:2] = a[9:2];
        PC     = p;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        set_pc(10'($urandom));
        tick();
        @(negedge CLK);
        check("rst_bw",    128'(BUSYWAIT),    128'(1'b0));
        check("rst_rd",    128'(MEM_READ),    128'(1'b0));
        check("rst_addr",  128'(MEM_ADDRESS), 128'(6'd0));
        check("rst_instr", 128'(INSTRUCTION), 128'(32'd0));
        tick();
        RESET = 1'b0;
        model_clear();
    endtask

    task automatic post_hit(input logic [9:0] a);
        @(negedge CLK);
        check("post_bw",    128'(BUSYWAIT),    128'(1'b0));
        check("post_instr", 128'(INSTRUCTION), 128'(word_of(m_data[a[6:4]], a[3:2])));
        m_hits++;
        tick();
    endtask

    task automatic fill_phase(input logic [5:0] blk, input int lat);
        for (int i = 0; i < lat; i++) begin
            @(negedge CLK);
            check("fetch_rd",   128'(MEM_READ),    128'(1'b1));
            check("fetch_addr", 128'(MEM_ADDRESS), 128'(blk));
            check("fetch_bw",   128'(BUSYWAIT),    128'(1'b1));
            tick();
        end
        @(negedge CLK);
        check("fill_rd", 128'(MEM_READ), 128'(1'b0));
        check("fill_bw", 128'(BUSYWAIT), 128'(1'b1));
        m_valid[blk[2:0]] = 1'b1;
        m_tag[blk[2:0]]   = blk[5:3];
        m_data[blk[2:0]]  = mem_img[blk];
        tick();
    endtask

    function automatic bit model_hit(input logic [9:0] a);
        return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[9:7]);
    endfunction

    task automatic do_fetch(input logic [9:0] a, input int lat);
        mem_lat = lat;
        set_pc(a);
        @(negedge CLK);
        if (model_hit(a)) begin
            check("hit_bw",    128'(BUSYWAIT),    128'(1'b0));
            check("hit_instr", 128'(INSTRUCTION), 128'(word_of(m_data[a[6:4]], a[3:2])));
            check("hit_rd",    128'(MEM_READ),    128'(1'b0));
            m_hits++;
            tick();
        end else begin
            check("miss_bw", 128'(BUSYWAIT), 128'(1'b1));
            check("miss_rd", 128'(MEM_READ), 128'(1'b0));
            m_misses++;
            tick();
            fill_phase({a[9:7], a[6:4]}, lat);
            post_hit(a);
        end
    endtask

    // CPU misbehaves: PC wanders during the fill, which must still land on the original line.
    task automatic do_violate(input logic [9:0] a, input int lat);
        if (model_hit(a)) begin
            do_fetch(a, lat);
        end else begin
            mem_lat = lat;
            set_pc(a);
            @(negedge CLK);
            check("vio_bw", 128'(BUSYWAIT), 128'(1'b1));
            m_misses++;
            tick();
            set_pc(10'($urandom));
            fill_phase({a[9:7], a[6:4]}, lat);
            set_pc(a);
            post_hit(a);
        end
    endtask

    task automatic check_stats();
`ifdef ICACHE_STATS_EN
        check("stat_hits",   128'(HIT_COUNT),  128'(16'(m_hits)));
        check("stat_misses", 128'(MISS_COUNT), 128'(16'(m_misses)));
`endif
    endtask

    initial begin
        int b0;
        RESET = 1'b1;
        PC    = '0;
        for (int i = 0; i < 64; i++) mem_img[i] = rand128();

        // Cold miss then spatial hits in the same block.
        do_reset();
        do_fetch(10'h000, 5);
        do_fetch(10'h004, 1);
        do_fetch(10'h008, 1);
        do_fetch(10'h00C, 1);
`ifdef ICACHE_STATS_EN
        check("stat_spatial_hits",   128'(HIT_COUNT),  128'(16'd4));
        check("stat_spatial_misses", 128'(MISS_COUNT), 128'(16'd1));
`endif

        // Conflict on index 1 between tags 0 and 1.
        do_reset();
        do_fetch(10'h010, 3);
        do_fetch(10'h090, 2);
        do_fetch(10'h010, 2);
        check_stats();

        // Reset while in FETCH aborts the fill.
        do_reset();
        mem_lat = 6;
        set_pc(10'h020);
        @(negedge CLK);
        check("abort_miss_bw", 128'(BUSYWAIT), 128'(1'b1));
        tick();
        tick();
        RESET = 1'b1;
        @(negedge CLK);
        check("abort_rst_rd", 128'(MEM_READ), 128'(1'b0));
        tick();
        RESET = 1'b0;
        model_clear();
        do_fetch(10'h020, 2);

        // Reset while in FILL must not write the line.
        mem_lat = 2;
        set_pc(10'h030);
        tick();
        tick();
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        model_clear();
        do_fetch(10'h030, 1);
        check_stats();

        // Four-instruction loop run ten times: one burst only.
        do_reset();
        b0 = bursts;
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < 4; k++) do_fetch(10'(k * 4), 3);
        end
        check("loop_bursts", 128'(bursts - b0), 128'(1));
        check_stats();

        // Random traffic, skewed to two tags so hits and conflicts both occur.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [9:0] a;
            int         lat;
            a   = {2'b00, 1'($urandom), 7'($urandom)};
            lat = $urandom_range(4, 1);
            if ($urandom_range(9, 0) == 0) do_violate(a, lat);
            else                           do_fetch(a, lat);
        end
        check_stats();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_controller.md
ICACHE_CONTROLLER -- requirements
Module: icache_controller

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed: 8 lines x 16 bytes, direct-mapped, 10-bit byte address space.
REQ-002 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 PC  input  32  CPU fetch byte address; bits [9:0] used, [1:0] ignored.
REQ-005 INSTRUCTION  output  32  fetched instruction word, valid when BUSYWAIT=0.
REQ-006 BUSYWAIT  output  1  high = CPU SHALL stall and hold PC.
REQ-007 MEM_ADDRESS  output  6  instruction-memory block address {tag,index}.
REQ-008 MEM_READ  output  1  block read request to instruction memory.
REQ-009 MEM_READDATA  input  128  returned block; byte 0 of block in bits [7:0].
REQ-010 MEM_BUSYWAIT  input  1  high while instruction memory is servicing the read.

Function
REQ-011 Address split SHALL be: offset = PC[3:2] (word), index = PC[6:4], tag = PC[9:7].
REQ-012 Each line SHALL hold valid bit, 3-bit tag, 128-bit data.
REQ-013 FSM states SHALL be IDLE, FETCH, FILL.
REQ-014 IDLE: hit = valid[index] and tag match, evaluated combinationally; on hit BUSYWAIT=0 and INSTRUCTION = word[offset] in the same cycle (zero-cycle hit).
REQ-015 IDLE miss: BUSYWAIT SHALL go high combinationally in the miss cycle; {tag,index} SHALL be latched; next state FETCH.
REQ-016 FETCH: MEM_READ=1, MEM_ADDRESS = latched {tag,index}, BUSYWAIT=1; stay while MEM_BUSYWAIT=1; on an edge with MEM_BUSYWAIT=0 go to FILL.
REQ-017 FILL: MEM_READ=0, BUSYWAIT=1; on the next edge write MEM_READDATA, latched tag and valid=1 into the latched index; go to IDLE.
REQ-018 Miss latency SHALL be: miss cycle + FETCH cycles (memory latency) + 1 FILL cycle, after which IDLE re-looks-up and hits.
REQ-019 Fills SHALL always overwrite the indexed line (no write-back; instruction side is read-only).
REQ-020 PC changing while BUSYWAIT=1 is a CPU protocol violation; the fill SHALL still use the latched address and never corrupt other lines.
REQ-021 MEM_READDATA SHALL be sampled only in FETCH on the terminating edge; at other times it is ignored.
REQ-022 Word extraction SHALL be little-endian: offset 0 = bits [31:0], offset 3 = bits [127:96].

Reset
REQ-023 On RESET=1 at a rising edge: state IDLE, all valid bits 0, latched address 0; tags/data need not be cleared.
REQ-024 While RESET=1: BUSYWAIT=0, MEM_READ=0, MEM_ADDRESS=0, INSTRUCTION=0.
REQ-025 RESET during FETCH or FILL SHALL abort the fill with no line written; MEM_READ SHALL be 0 from the next cycle.

Configuration
REQ-026 Macro ICACHE_STATS_EN: when defined, ports HIT_COUNT (output, 16) and MISS_COUNT (output, 16) SHALL exist; each IDLE hit cycle with BUSYWAIT=0 increments HIT_COUNT, each miss detection increments MISS_COUNT, both saturate at 16'hFFFF and reset to 0.
REQ-027 When ICACHE_STATS_EN is undefined, those ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-028 Cold miss: reset, PC=0x000, memory latency 5 cycles -> BUSYWAIT=1, MEM_READ=1 with MEM_ADDRESS=6'h00 for 5 cycles, one FILL cycle, then BUSYWAIT=0 and INSTRUCTION=MEM_READDATA[31:0].
REQ-029 Spatial hit: after REQ-028, PC=0x004, 0x008, 0x00C -> BUSYWAIT=0 each cycle, INSTRUCTION = block words 1,2,3, MEM_READ never asserted.
REQ-030 Conflict: fill PC=0x010 (index 1, tag 0), then PC=0x090 (index 1, tag 1) -> miss with MEM_ADDRESS=6'h09; then PC=0x010 -> miss again with MEM_ADDRESS=6'h01.
REQ-031 Reset mid-fill: miss on PC=0x020, assert RESET during FETCH -> MEM_READ=0 next cycle, after release PC=0x020 misses again (valid[2]=0).
REQ-032 Stats (ICACHE_STATS_EN defined): run REQ-028 then REQ-029 -> MISS_COUNT=1, HIT_COUNT=4.
REQ-033 Loop program: 4-instruction loop at 0x000-0x00C executed 10 times -> exactly one MEM_READ burst total.
